// File: rtl/fe_fifo_reader_if.sv
// FIFO read port and output byte stream of fe_fifo_reader.
// master: the reader side; slave: FIFO + byte consumer side.
interface fe_fifo_reader_if #(
    parameter int unsigned pTIME_WIDTH = 16,
    parameter int unsigned pDATA_WIDTH = 8
);
    logic                                 I_fifo_empty;
    logic [2+pTIME_WIDTH+pDATA_WIDTH-1:0] I_fifo_dout;
    logic                                 O_fifo_rd;
    logic [7:0]                           O_byte;
    logic                                 O_byte_valid;
    logic                                 I_byte_ready;

    modport master (
        input  I_fifo_empty, I_fifo_dout, I_byte_ready,
        output O_fifo_rd, O_byte, O_byte_valid
    );

    modport slave (
        output I_fifo_empty, I_fifo_dout, I_byte_ready,
        input  O_fifo_rd, O_byte, O_byte_valid
    );
endinterface

// File: rtl/fe_fifo_reader.sv
// Front-end capture FIFO reader (cwusb_clk domain).
// Pops {cmd, time, data} entries, folds TIME entries into a saturating delta
// accumulator and serialises data entries as: header byte, optional 3-byte
// long timestamp (LSB first), data bytes (LSB first).
// Optional statistics counters: define FE_FIFO_READER_STATS_EN.
module fe_fifo_reader #(
    parameter int unsigned pTIME_WIDTH = 16,
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pACC_WIDTH  = 24,
    parameter logic [1:0]  pCMD_TIME   = 2'b10,
    parameter int unsigned pSHORT_MAX  = 31
) (
    input  logic                  cwusb_clk,
    input  logic                  reset_n,
    input  logic                  I_clear,
    fe_fifo_reader_if.master      bus,
    output logic                  O_acc_saturated,
    output logic                  O_busy
`ifdef FE_FIFO_READER_STATS_EN
    ,
    output logic [31:0]           O_event_count,
    output logic [15:0]           O_time_count
`endif
);

    localparam int unsigned TS_BYTES   = pACC_WIDTH / 8;
    localparam int unsigned DATA_BYTES = pDATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DECODE,
        ST_HDR,
        ST_TS,
        ST_DATA
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [1:0]              entry_cmd;
    logic [pTIME_WIDTH-1:0]  entry_time;
    logic [pDATA_WIDTH-1:0]  entry_data;
    logic [pACC_WIDTH-1:0]   acc;
    logic [pACC_WIDTH-1:0]   delta_sr;
    logic [2:0]              byte_cnt;
    logic                    acc_sat;

    logic [pACC_WIDTH:0]     sum;
    logic [pACC_WIDTH-1:0]   sum_sat;
    logic                    sum_hit;
    logic                    is_time;
    logic                    is_short;
    logic                    last_ts;
    logic                    last_data;
    logic                    xfer;

    logic                    fifo_rd;
    logic                    byte_valid;
    logic [7:0]              byte_out;

    // Saturating sum of accumulator and the decoded entry's time field
    always_comb begin
        sum     = {1'b0, acc} + {{(pACC_WIDTH + 1 - pTIME_WIDTH){1'b0}}, entry_time};
        sum_sat = sum[pACC_WIDTH] ? '1 : sum[pACC_WIDTH-1:0];
        sum_hit = sum[pACC_WIDTH] || (&sum[pACC_WIDTH-1:0]);
    end

    assign is_time   = (entry_cmd == pCMD_TIME);
    assign is_short  = (delta_sr <= pACC_WIDTH'(pSHORT_MAX));
    assign last_ts   = (byte_cnt == 3'(TS_BYTES - 1));
    assign last_data = (byte_cnt == 3'(DATA_BYTES - 1));
    assign xfer      = byte_valid && bus.I_byte_ready;

    // Next-state and output decode; I_clear overrides every transition
    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        case (state)
            ST_IDLE: begin
                if (!bus.I_fifo_empty && !I_clear) begin
                    fifo_rd    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = is_time ? ST_IDLE : ST_HDR;
            end
            ST_HDR: begin
                byte_valid = 1'b1;
                byte_out   = is_short ? {entry_cmd, 1'b0, delta_sr[4:0]}
                                      : {entry_cmd, 1'b1, 5'b00000};
                if (xfer) begin
                    state_next = is_short ? ST_DATA : ST_TS;
                end
            end
            ST_TS: begin
                byte_valid = 1'b1;
                byte_out   = delta_sr[7:0];
                if (xfer && last_ts) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                byte_valid = 1'b1;
                byte_out   = entry_data[7:0];
                if (xfer && last_data) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (I_clear) begin
            state_next = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Entry latch, accumulator, timestamp/data shifters and byte counter
    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_cmd  <= '0;
            entry_time <= '0;
            entry_data <= '0;
            acc        <= '0;
            delta_sr   <= '0;
            byte_cnt   <= '0;
            acc_sat    <= 1'b0;
        end else if (I_clear) begin
            acc      <= '0;
            byte_cnt <= '0;
            acc_sat  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    {entry_cmd, entry_time, entry_data} <= bus.I_fifo_dout;
                end
                ST_DECODE: begin
                    if (is_time) begin
                        acc <= sum_sat;
                    end else begin
                        delta_sr <= sum_sat;
                        acc      <= '0;
                    end
                    if (sum_hit) begin
                        acc_sat <= 1'b1;
                    end
                    byte_cnt <= '0;
                end
                ST_TS: begin
                    if (xfer) begin
                        delta_sr <= delta_sr >> 8;
                        byte_cnt <= last_ts ? 3'd0 : byte_cnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        entry_data <= entry_data >> 8;
                        byte_cnt   <= last_data ? 3'd0 : byte_cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FE_FIFO_READER_STATS_EN
    // Saturating counters of completed data events and decoded TIME entries
    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_event_count <= '0;
            O_time_count  <= '0;
        end else if (I_clear) begin
            O_event_count <= '0;
            O_time_count  <= '0;
        end else begin
            if (state == ST_DECODE && is_time && O_time_count != '1) begin
                O_time_count <= O_time_count + 16'd1;
            end
            if (state == ST_DATA && xfer && last_data && O_event_count != '1) begin
                O_event_count <= O_event_count + 32'd1;
            end
        end
    end
`endif

    assign bus.O_fifo_rd    = fifo_rd;
    assign bus.O_byte_valid = byte_valid;
    assign bus.O_byte       = byte_out;
    assign O_acc_saturated  = acc_sat;
    assign O_busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Scoreboard bench for fe_fifo_reader: directed FIFO entries with
// hand-computed byte streams; a forked monitor pops and compares each
// transferred byte.
module tb_fe_fifo_reader;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        acc_saturated;
    logic        busy;
`ifdef FE_FIFO_READER_STATS_EN
    logic [31:0] event_count;
    logic [15:0] time_count;
`endif

    int unsigned tests;
    int unsigned fails;
    logic [7:0]  exp_q[$];

    logic [25:0] fifo_mem[0:1023];
    logic [9:0]  wr_ptr;
    logic [9:0]  rd_ptr;
    logic [25:0] fifo_dout;
    int unsigned rd_count;
    logic        rd_while_empty;

    fe_fifo_reader_if #(.pTIME_WIDTH(16), .pDATA_WIDTH(8)) bus ();

    fe_fifo_reader #(
        .pTIME_WIDTH(16),
        .pDATA_WIDTH(8),
        .pACC_WIDTH(24),
        .pCMD_TIME(2'b10),
        .pSHORT_MAX(31)
    ) dut (
        .cwusb_clk       (clk),
        .reset_n         (rst_n),
        .I_clear         (clear),
        .bus             (bus),
        .O_acc_saturated (acc_saturated),
        .O_busy          (busy)
`ifdef FE_FIFO_READER_STATS_EN
        ,
        .O_event_count   (event_count),
        .O_time_count    (time_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.I_fifo_empty = (wr_ptr == rd_ptr);
    assign bus.I_fifo_dout  = fifo_dout;

    // Standard-read FIFO model: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (bus.O_fifo_rd) begin
            if (wr_ptr == rd_ptr) rd_while_empty <= 1'b1;
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
            rd_count  <= rd_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
        fifo_mem[wr_ptr] = {c, t, d};
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bus.O_byte_valid && bus.I_byte_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL byte_unexpected: got 0x%0h expected none", bus.O_byte);
                end else begin
                    chk("byte", {24'h0, bus.O_byte}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned n = 0;
        while (!bus.O_byte_valid && n < budget) begin
            step();
            n++;
        end
        chk("wait_valid", {31'h0, bus.O_byte_valid}, 32'h1);
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while (!(exp_q.size() == 0 && !busy && wr_ptr == rd_ptr) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'h0);
        chk("drain_busy", {31'h0, busy}, 32'h0);
    endtask

    task automatic xfer_one();
        wait_valid(20);
        bus.I_byte_ready = 1'b1;
        step();
        bus.I_byte_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int unsigned rc0;
        tests = 0;
        fails = 0;
        wr_ptr = '0;
        rd_ptr = '0;
        fifo_dout = '0;
        rd_count = 0;
        rd_while_empty = 1'b0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.I_byte_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        step();
        step();
        chk("rst_valid", {31'h0, bus.O_byte_valid}, 32'h0);
        chk("rst_byte", {24'h0, bus.O_byte}, 32'h0);
        chk("rst_rd", {31'h0, bus.O_fifo_rd}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_sat", {31'h0, acc_saturated}, 32'h0);
        rst_n = 1'b1;
        step();

        // Short event: 3-cycle latency, header 0x05 then data 0xA7
        bus.I_byte_ready = 1'b1;
        rc0 = rd_count;
        exp_q.push_back(8'h05);
        exp_q.push_back(8'hA7);
        push(2'd0, 16'd5, 8'hA7);
        #1;
        chk("short_rd", {31'h0, bus.O_fifo_rd}, 32'h1);
        step();
        chk("short_busy", {31'h0, busy}, 32'h1);
        step();
        chk("short_lat2", {31'h0, bus.O_byte_valid}, 32'h0);
        step();
        chk("short_lat3", {31'h0, bus.O_byte_valid}, 32'h1);
        chk("short_hdr", {24'h0, bus.O_byte}, 32'h05);
        step();
        chk("short_data", {24'h0, bus.O_byte}, 32'hA7);
        step();
        chk("short_idle", {31'h0, busy}, 32'h0);
        chk("short_rdcnt", rd_count - rc0, 32'd1);
        wait_drain(20);

        // Long event built from two TIME entries: delta 0x010012
        pulse_clear();
        rc0 = rd_count;
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h11);
        push(2'b10, 16'hFFFF, 8'h00);
        push(2'b10, 16'h0010, 8'h00);
        push(2'd1, 16'd3, 8'h11);
        wait_drain(100);
        chk("long_rdcnt", rd_count - rc0, 32'd3);
        chk("long_sat", {31'h0, acc_saturated}, 32'h0);
`ifdef FE_FIFO_READER_STATS_EN
        chk("stats_time", {16'h0, time_count}, 32'd2);
        chk("stats_event", event_count, 32'd1);
        pulse_clear();
        chk("stats_time_clr", {16'h0, time_count}, 32'd0);
        chk("stats_event_clr", event_count, 32'd0);
`endif

        // Backpressure: header held, no prefetch while stalled
        bus.I_byte_ready = 1'b0;
        rc0 = rd_count;
        exp_q.push_back(8'h05);
        exp_q.push_back(8'hA7);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h3C);
        push(2'd0, 16'd5, 8'hA7);
        push(2'd0, 16'd2, 8'h3C);
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            chk("bp_byte", {24'h0, bus.O_byte}, 32'h05);
            chk("bp_valid", {31'h0, bus.O_byte_valid}, 32'h1);
            chk("bp_rdcnt", rd_count - rc0, 32'd1);
            step();
        end
        bus.I_byte_ready = 1'b1;
        wait_drain(50);
        chk("bp_rdcnt_end", rd_count - rc0, 32'd2);

        // Saturation: 300 x 0xFFFF overflows 24 bits
        pulse_clear();
        for (int i = 0; i < 300; i++) push(2'b10, 16'hFFFF, 8'h00);
        push(2'd0, 16'd0, 8'hC3);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hC3);
        wait_drain(2000);
        chk("sat_flag", {31'h0, acc_saturated}, 32'h1);
        step();
        step();
        chk("sat_sticky", {31'h0, acc_saturated}, 32'h1);
        pulse_clear();
        chk("sat_clear", {31'h0, acc_saturated}, 32'h0);

        // Clear during first TS byte: event abandoned
        bus.I_byte_ready = 1'b0;
        exp_q.push_back(8'h60);
        push(2'b10, 16'h0040, 8'h00);
        push(2'd1, 16'd0, 8'h33);
        xfer_one();
        chk("clr_ts_byte", {24'h0, bus.O_byte}, 32'h40);
        pulse_clear();
        chk("clr_valid", {31'h0, bus.O_byte_valid}, 32'h0);
        chk("clr_busy", {31'h0, busy}, 32'h0);
        chk("clr_left", exp_q.size(), 32'h0);
        exp_q.delete();

        // Clear wipes a pending accumulated TIME value
        push(2'b10, 16'h0009, 8'h00);
        for (int i = 0; i < 6; i++) step();
        pulse_clear();
        bus.I_byte_ready = 1'b1;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h5A);
        push(2'd0, 16'd7, 8'h5A);
        wait_drain(30);

        // Reset during DATA: outputs drop without a clock edge
        bus.I_byte_ready = 1'b0;
        exp_q.push_back(8'h01);
        push(2'd0, 16'd1, 8'h77);
        xfer_one();
        chk("rstm_data", {24'h0, bus.O_byte}, 32'h77);
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", {31'h0, bus.O_byte_valid}, 32'h0);
        chk("rstm_byte", {24'h0, bus.O_byte}, 32'h0);
        chk("rstm_busy", {31'h0, busy}, 32'h0);
        chk("rstm_rd", {31'h0, bus.O_fifo_rd}, 32'h0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        bus.I_byte_ready = 1'b1;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h99);
        push(2'd0, 16'd3, 8'h99);
        wait_drain(30);
`ifdef FE_FIFO_READER_STATS_EN
        chk("stats_after_rst", event_count, 32'd1);
`endif

        chk("rd_while_empty", {31'h0, rd_while_empty}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fe_fifo_reader.md
Name: fe_fifo_reader

Overview:
- Read side of the front-end capture FIFO; sits in the cwusb_clk domain between the FIFO read port and the USB readout register.
- Pops entries of the form {command, time, data} and folds TIME entries into a running delta accumulator.
- Serialises each data entry into a compact byte stream:
  - a header byte, then
  - optionally a 3-byte long timestamp, then
  - the data bytes.

Parameters:
- pTIME_WIDTH, 16, width of the time field in each FIFO entry.
- pDATA_WIDTH, 8, width of the data field; must be a multiple of 8, max 32.
- pACC_WIDTH, 24, width of the delta accumulator and of the long-timestamp field.
- pCMD_TIME, 2'b10, command code marking a time-only entry.
- pSHORT_MAX, 31, largest delta encodable in the header byte (5 bits).

Ports:
- cwusb_clk  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- I_fifo_empty  in  1  FIFO empty flag.
- I_fifo_dout  in  2+pTIME_WIDTH+pDATA_WIDTH  FIFO read data {cmd, time, data}, standard (non-FWFT) read, valid 1 cycle after O_fifo_rd.
- O_fifo_rd  out  1  FIFO read strobe.
- I_clear  in  1  synchronous clear: accumulator, sticky flag, and state back to IDLE.
- O_byte  out  8  output byte.
- O_byte_valid  out  1  O_byte valid.
- I_byte_ready  in  1  consumer accepts O_byte this cycle.
- O_acc_saturated  out  1  sticky: accumulator hit all-ones since last clear/reset.
- O_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, cwusb_clk; reset_n is asynchronous, active-low.
- Reset values: O_fifo_rd=0, O_byte_valid=0, O_byte=0, O_acc_saturated=0, O_busy=0; accumulator=0; state=IDLE.
- State IDLE:
  - If !I_fifo_empty: assert O_fifo_rd for exactly one cycle, go to WAIT.
  - O_fifo_rd is never asserted while I_fifo_empty=1.
- State WAIT: latch I_fifo_dout into an entry register, go to DECODE.
- State DECODE:
  - cmd==pCMD_TIME:
    - acc <= sat(acc + time).
    - Back to IDLE; no output.
  - Otherwise:
    - delta = sat(acc + time).
    - acc <= 0.
    - Load delta into the shift register and go to HDR.
- Saturation: any sum > 2^pACC_WIDTH-1 clamps to all-ones and sets O_acc_saturated.
- State HDR:
  - delta <= pSHORT_MAX: O_byte={cmd, 1'b0, delta[4:0]}, next is DATA.
  - Else: O_byte={cmd, 1'b1, 5'b0}, next is TS.
- State TS: emits delta LSB-first, 3 bytes (pACC_WIDTH/8), then goes to DATA.
- State DATA: emits data LSB-first, pDATA_WIDTH/8 bytes, then goes to IDLE.
- Output handshake:
  - O_byte_valid is high throughout HDR/TS/DATA.
  - O_byte stays stable until I_byte_ready=1; a byte transfers on the cycle with valid&&ready.
  - The byte counter advances only on transfer.
  - I_byte_ready while !O_byte_valid is ignored.
- Throughput:
  - Minimum latency from FIFO non-empty to the first O_byte_valid is 3 cycles (IDLE→WAIT→DECODE→HDR).
  - Back-to-back entries: the next read is issued in the IDLE cycle after the last byte transfers.
  - No prefetch.
- Time entries back-to-back: each costs 3 cycles and accumulates; the order of TIME entries has no effect.
- I_clear:
  - Has priority over all other transitions.
  - A partially sent event is abandoned: O_byte_valid drops the next cycle.
  - A pending FIFO read (WAIT) is discarded.
- reset_n mid-transfer: outputs take their reset values immediately (asynchronously); the entry is lost.
- O_busy = (state != IDLE); the readout firmware polls it together with I_fifo_empty.

Optional Feature:
- Macro: FE_FIFO_READER_STATS_EN.
- When defined:
  - Adds outputs O_event_count[31:0] and O_time_count[15:0].
  - O_event_count counts completed data events, incrementing on the last byte's transfer.
  - O_time_count counts TIME entries decoded.
  - Both counters saturate, reset to 0, and clear on I_clear.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Short event: single entry {cmd=0, time=5, data=0xA7}, ready tied 1 -> bytes 0x05, 0xA7; acc=0 after; O_busy low 1 cycle after the last byte.
- Long via TIME: entries {TIME, 0xFFFF}, {TIME, 0x0010}, {cmd=1, time=3, data=0x11} -> bytes 0x60, 0x12, 0x00, 0x01, 0x11 (delta=0x010012); one O_fifo_rd per entry.
- Backpressure: short event with I_byte_ready low 10 cycles -> O_byte holds 0x05 stable, valid stays high, no further FIFO reads; after ready, 0xA7 follows.
- Saturation: 300 TIME entries of 0xFFFF then {cmd=0, time=0} -> header 0x20, TS bytes 0xFF 0xFF 0xFF, O_acc_saturated=1 until I_clear.
- Clear/reset mid-event: I_clear during TS byte 1 -> valid drops next cycle, acc=0, next event starts with a fresh header; reset_n pulse mid-DATA -> all outputs 0 immediately.
- Stats (FE_FIFO_READER_STATS_EN): the Long via TIME sequence -> O_time_count=2, O_event_count=1; I_clear -> both 0.
